pixel_loader: RTL and testbench

Upstream stage of the pixel-processing pipeline. It takes a byte stream from the UART receiver, assembles each three consecutive bytes into one 24-bit RGB pixel and writes the pixels sequentially into the source pixel RAM (RAM_ADDR_BITS=10, RAM_WIDTH=24) that the read/filter/write sequencer later drains. It runs one frame per `start` pulse, flags a truncated pixel via timeout, and reports completion.

---
 rtl/pixel_loader.sv | 158 +++++++++++++++
 tb/tb_pixel_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_loader.sv
// Assembles R,G,B bytes from the UART receiver into 24-bit pixels and writes
// them sequentially into the source pixel RAM, one frame per start pulse.
module pixel_loader #(
   parameter int RAM_ADDR_BITS = 10,
   parameter int RAM_WIDTH     = 24,
   parameter int NUM_PIXELS    = 1024,
   parameter int TIMEOUT       = 50_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     rx_done_tick,
   input  logic [7:0]               rx_data,
   output logic                     we,
   output logic [RAM_ADDR_BITS-1:0] addr,
   output logic [RAM_WIDTH-1:0]     wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [RAM_ADDR_BITS-1:0] LAST_PIXEL = RAM_ADDR_BITS'(NUM_PIXELS - 1);
   localparam logic [TW-1:0]            TIME_LIMIT = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      GET_R,
      GET_G,
      GET_B,
      WRITE,
      DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic [RAM_ADDR_BITS-1:0] r_pixCount;
   logic [RAM_ADDR_BITS-1:0] w_nextCount;
   logic [TW-1:0]            r_timer;
   logic [TW-1:0]            w_nextTimer;
   logic [RAM_WIDTH-1:0]     r_wdata;
   logic [RAM_WIDTH-1:0]     w_nextData;
   logic                     r_err;
   logic                     w_nextErr;
   logic                     r_we;
   logic [RAM_ADDR_BITS-1:0] r_addr;
   logic                     r_busy;
   logic                     r_done;

   // Next-state logic; a tick during a non-final WRITE is taken as the next R byte.
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_pixCount;
      w_nextTimer = r_timer;
      w_nextData  = r_wdata;
      w_nextErr   = r_err;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_nextState = GET_R;
               w_nextCount = '0;
               w_nextTimer = '0;
               w_nextErr   = 1'b0;
            end
         end
         GET_R: begin
            w_nextTimer = '0;
            if (rx_done_tick) begin
               w_nextData[RAM_WIDTH-1 -: 8] = rx_data;
               w_nextState = GET_G;
            end
         end
         GET_G: begin
            if (rx_done_tick) begin
               w_nextData[RAM_WIDTH-9 -: 8] = rx_data;
               w_nextState = GET_B;
               w_nextTimer = '0;
            end else if (r_timer == TIME_LIMIT) begin
               w_nextState = GET_R;
               w_nextTimer = '0;
               w_nextErr   = 1'b1;
            end else begin
               w_nextTimer = r_timer + TW'(1);
            end
         end
         GET_B: begin
            if (rx_done_tick) begin
               w_nextData[7:0] = rx_data;
               w_nextState = WRITE;
               w_nextTimer = '0;
            end else if (r_timer == TIME_LIMIT) begin
               w_nextState = GET_R;
               w_nextTimer = '0;
               w_nextErr   = 1'b1;
            end else begin
               w_nextTimer = r_timer + TW'(1);
            end
         end
         WRITE: begin
            w_nextTimer = '0;
            if (r_pixCount == LAST_PIXEL) begin
               w_nextState = DONE;
            end else begin
               w_nextCount = r_pixCount + RAM_ADDR_BITS'(1);
               if (rx_done_tick) begin
                  w_nextData[RAM_WIDTH-1 -: 8] = rx_data;
                  w_nextState = GET_G;
               end else begin
                  w_nextState = GET_R;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_pixCount <= '0;
         r_timer    <= '0;
         r_wdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_pixCount <= w_nextCount;
         r_timer    <= w_nextTimer;
         r_wdata    <= w_nextData;
         r_err      <= w_nextErr;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_we   <= (w_nextState == WRITE);
         if (w_nextState == WRITE) begin
            r_addr <= w_nextCount;
         end
         r_busy <= (w_nextState == GET_R) || (w_nextState == GET_G) ||
                   (w_nextState == GET_B) || (w_nextState == WRITE);
         r_done <= (w_nextState == DONE);
      end
   end

   assign we    = r_we;
   assign addr  = r_addr;
   assign wdata = r_wdata;
   assign busy  = r_busy;
   assign done  = r_done;
   assign err   = r_err;

endmodule

// File: tb/tb_pixel_loader.sv
// Directed testbench for pixel_loader with a small frame (4 pixels) and a
// short timeout (16 cycles) so every corner is reachable quickly.
module tb_pixel_loader;

   localparam int AB  = 10;
   localparam int NPX = 4;
   localparam int TO  = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          rx_done_tick = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          we;
   logic [AB-1:0] addr;
   logic [23:0]   wdata;
   logic          busy;
   logic          done;
   logic          err;

   int nVectors = 0;
   int nFail    = 0;

   typedef struct {
      logic          st;
      logic          tk;
      logic [7:0]    d;
      logic          we;
      logic [AB-1:0] a;
      logic [23:0]   w;
      logic          bz;
      logic          dn;
      logic          er;
      logic          chkAw;
   } vec_t;

   vec_t vecs[$];

   pixel_loader #(
      .RAM_ADDR_BITS(AB),
      .RAM_WIDTH(24),
      .NUM_PIXELS(NPX),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .rx_done_tick(rx_done_tick),
      .rx_data(rx_data),
      .we(we),
      .addr(addr),
      .wdata(wdata),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic tk, input logic [7:0] d,
                               input logic ewe, input logic [AB-1:0] ea, input logic [23:0] ew,
                               input logic ebz, input logic edn, input logic eer, input logic chk);
      vec_t v;
      v.st = st; v.tk = tk; v.d = d; v.we = ewe; v.a = ea; v.w = ew;
      v.bz = ebz; v.dn = edn; v.er = eer; v.chkAw = chk;
      return v;
   endfunction

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic applyStimulus(input logic st, input logic tk, input logic [7:0] d);
      start        = st;
      rx_done_tick = tk;
      rx_data      = d;
      @(posedge clk);
      #1;
      start        = 1'b0;
      rx_done_tick = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".we"},   32'(we),    32'd0);
      checkOutput({tag, ".busy"}, 32'(busy),  32'd0);
      checkOutput({tag, ".done"}, 32'(done),  32'd0);
      checkOutput({tag, ".err"},  32'(err),   32'd0);
      checkOutput({tag, ".addr"}, 32'(addr),  32'd0);
   endtask

   initial begin
      // Table: idle tick, full frame back to back, dropped/ignored ticks,
      // restart from DONE, start while busy.
      vecs.push_back(mk(0, 1, 8'h99, 0, 0, 24'h000000, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 24'h000000, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 8'h11, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h22, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h33, 1, 0, 24'h112233, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 8'h44, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h55, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h66, 1, 1, 24'h445566, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 8'h77, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h88, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h99, 1, 2, 24'h778899, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hBB, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hCC, 1, 3, 24'hAABBCC, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 8'hDD, 0, 3, 24'hAABBCC, 0, 1, 0, 1));
      vecs.push_back(mk(0, 1, 8'hEE, 0, 3, 24'hAABBCC, 0, 1, 0, 1));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h01, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h02, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h03, 1, 0, 24'h010203, 1, 0, 0, 1));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hAB, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hCD, 0, 0, 24'h0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'hEF, 1, 1, 24'hABCDEF, 1, 0, 0, 1));

      // Reset held with random activity: outputs must stay cleared.
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         checkIdleOutputs($sformatf("rstHold%0d", i));
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkIdleOutputs($sformatf("postRst%0d", i));
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].st, vecs[i].tk, vecs[i].d);
         checkOutput($sformatf("row%0d.we", i),   32'(we),   32'(vecs[i].we));
         checkOutput($sformatf("row%0d.busy", i), 32'(busy), 32'(vecs[i].bz));
         checkOutput($sformatf("row%0d.done", i), 32'(done), 32'(vecs[i].dn));
         checkOutput($sformatf("row%0d.err", i),  32'(err),  32'(vecs[i].er));
         if (vecs[i].chkAw) begin
            checkOutput($sformatf("row%0d.addr", i),  32'(addr),  32'(vecs[i].a));
            checkOutput($sformatf("row%0d.wdata", i), 32'(wdata), 32'(vecs[i].w));
         end
      end

      // Timeout: one byte, then silence; err rises exactly after 17 idle cycles.
      reset = 1'b0;
      #2;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'hAA);
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput($sformatf("toWait%0d.we", i), 32'(we), 32'd0);
      end
      checkOutput("toBefore.err", 32'(err), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("toAfter.err",  32'(err),  32'd1);
      checkOutput("toAfter.busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
      end
      checkOutput("toIdleGetR.err", 32'(err), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h01);
      applyStimulus(1'b0, 1'b1, 8'h02);
      applyStimulus(1'b0, 1'b1, 8'h03);
      checkOutput("toPix.we",    32'(we),    32'd1);
      checkOutput("toPix.addr",  32'(addr),  32'd0);
      checkOutput("toPix.wdata", 32'(wdata), 32'h010203);
      checkOutput("toPix.err",   32'(err),   32'd1);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("toPix2.we",  32'(we),  32'd0);
      checkOutput("toPix2.err", 32'(err), 32'd1);

      // Reset mid-frame after 5 bytes, then a fresh frame starts at address 0.
      reset = 1'b0;
      #2;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h10);
      applyStimulus(1'b0, 1'b1, 8'h20);
      applyStimulus(1'b0, 1'b1, 8'h30);
      applyStimulus(1'b0, 1'b1, 8'h40);
      applyStimulus(1'b0, 1'b1, 8'h50);
      checkOutput("midPre.busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkIdleOutputs("midRst");
      checkOutput("midRst.wdata", 32'(wdata), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 8'h77);
      checkIdleOutputs("midRstTick");
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h5A);
      applyStimulus(1'b0, 1'b1, 8'hA5);
      applyStimulus(1'b0, 1'b1, 8'h3C);
      checkOutput("midNew.we",    32'(we),    32'd1);
      checkOutput("midNew.addr",  32'(addr),  32'd0);
      checkOutput("midNew.wdata", 32'(wdata), 32'h5AA53C);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
